// File: rtl/sw_2port_ram_p.sv
// Parametrised two-port SRAM model: port A synchronous read, port B byte-group write,
// with a post-reset clear sequencer. Define SW2P_BYPASS_EN for same-address write-through.
module sw_2port_ram_p #(
    parameter int AW      = 5,
    parameter int DW      = 12,
    parameter int BW      = 12,
    parameter int OUT_REG = 0,
    localparam int NB     = DW / BW,
    localparam int DEPTH  = 2 ** AW
) (
    input  logic          CK,
    input  logic          RSTB,
    input  logic [AW-1:0] A,
    input  logic          CSA,
    input  logic          OE,
    output logic [DW-1:0] DO,
    output logic          DOV,
    input  logic [AW-1:0] B,
    input  logic          CSB,
    input  logic [NB-1:0] WEB,
    input  logic [DW-1:0] DI,
    output logic          BUSY
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          clr_we;
    logic          ready;
    logic          rd_en;
    logic          wr_en;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] do_q;
    logic          dov_q;
    logic [DW-1:0] dout;
    logic          dout_v;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking for every register so all state updates see pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    assign ready = (state_q == READY);
    assign BUSY  = ~ready;
    assign rd_en = ready & CSA;
    assign wr_en = ready & CSB;

    // NOTE: the array has no reset; the clear sequencer zeroes it after RSTB rises instead.
    always_ff @(posedge CK) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (!WEB[i]) begin
                    mem[B][i*BW +: BW] <= DI[i*BW +: BW];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[A];
`ifdef SW2P_BYPASS_EN
        // Groups written on this same edge are forwarded from DI.
        if (wr_en && (B == A)) begin
            for (int i = 0; i < NB; i++) begin
                if (!WEB[i]) begin
                    rd_word[i*BW +: BW] = DI[i*BW +: BW];
                end
            end
        end
`endif
    end

    always_ff @(posedge CK or negedge RSTB) begin
        if (!RSTB) begin
            do_q  <= '0;
            dov_q <= 1'b0;
        end else begin
            dov_q <= rd_en;
            if (rd_en) begin
                do_q <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] do2_q;
            logic          dov2_q;

            always_ff @(posedge CK or negedge RSTB) begin
                if (!RSTB) begin
                    do2_q  <= '0;
                    dov2_q <= 1'b0;
                end else begin
                    dov2_q <= dov_q;
                    if (dov_q) begin
                        do2_q <= do_q;
                    end
                end
            end

            assign dout   = do2_q;
            assign dout_v = dov2_q;
        end else begin : g_no_out_reg
            assign dout   = do_q;
            assign dout_v = dov_q;
        end
    endgenerate

    // OE gates only the pins; the held read data survives OE going low.
    assign DO  = OE ? dout : '0;
    assign DOV = dout_v;

endmodule
